// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Request/operand/result bundle between two requesters and the
//            shared-ALU arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int W = 16
);
    logic         req0;
    logic         req1;
    logic [1:0]   op0;
    logic [1:0]   op1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic [W-1:0] result;
    logic [2:0]   status0;
    logic [2:0]   status1;
    logic         busy;

    // Requester side: drives requests and operands, observes handshakes
    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, result, status0, status1, busy
    );

    // Arbiter side
    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, result, status0, status1, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one W-bit ALU between two requesters.
//            IDLE -> EXEC -> RESP per transaction, registered grant/done
//            pulses, registered result, per-requester {N,V,Z} status that
//            only compare (op 01) operations update.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_CMP = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;

    state_t       r_state;
    logic         r_owner;
    logic         r_last;
    logic [1:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_gnt0;
    logic         r_gnt1;
    logic         r_done0;
    logic         r_done1;
    logic [W-1:0] r_result;
    logic [2:0]   r_status0;
    logic [2:0]   r_status1;

    logic         w_win;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_alu;
    logic         w_v;
    logic [2:0]   w_nvz;

    // Under contention the requester that was not served last wins;
    // otherwise whoever is requesting wins (1 = requester 1).
    assign w_win = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;

    // Shared ALU on the captured operands; V is signed overflow for add/sub
    always_comb begin
        w_alu = ~r_b;
        w_v   = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_alu = w_sum;
                w_v   = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
            end
            c_OP_CMP: begin
                w_alu = w_diff;
                w_v   = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
            end
            c_OP_AND: begin
                w_alu = r_a & r_b;
            end
            default: begin
                w_alu = ~r_b;
            end
        endcase
    end

    assign w_nvz = {w_alu[W-1], w_v, (w_alu == '0)};

    // Arbitration FSM with registered handshakes, result and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_op      <= 2'b00;
            r_a       <= '0;
            r_b       <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_result  <= '0;
            r_status0 <= 3'b000;
            r_status1 <= 3'b000;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_op    <= w_win ? bus.op1 : bus.op0;
                        r_a     <= w_win ? bus.a1  : bus.a0;
                        r_b     <= w_win ? bus.b1  : bus.b0;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= w_alu;
                    r_done0  <= ~r_owner;
                    r_done1  <= r_owner;
                    if (r_op == c_OP_CMP) begin
                        if (r_owner) begin
                            r_status1 <= w_nvz;
                        end else begin
                            r_status0 <= w_nvz;
                        end
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;
    assign bus.result  = r_result;
    assign bus.status0 = r_status0;
    assign bus.status1 = r_status1;
    assign bus.busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter: directed scenarios
//            followed by randomized requesters against a transaction-level
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    bit   drop_next0 = 1'b0;
    bit   drop_next1 = 1'b0;

    alu_share_arbiter_if #(.W(W)) bus ();

    alu_share_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU using signed integer arithmetic: {result, N, V, Z}
    function automatic logic [18:0] alu_ref(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int         sa, sb, s;
        logic [15:0] r;
        logic        v;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        v  = 1'b0;
        case (op)
            2'd0: begin s = sa + sb; v = (s > 32767) || (s < -32768); r = 16'(s); end
            2'd1: begin s = sa - sb; v = (s > 32767) || (s < -32768); r = 16'(s); end
            2'd2: r = a & b;
            default: r = ~b;
        endcase
        return {r, r[15], v, (r == 16'h0000)};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- reference model ----------------
    // m_age: cycles since the transaction was granted (0 = no transaction)
    int          m_age;
    bit          m_last;
    bit          m_owner;
    logic [1:0]  m_op;
    logic [15:0] m_a, m_b;
    logic        e_gnt0, e_gnt1, e_done0, e_done1;
    logic [15:0] e_result;
    logic [2:0]  e_st0, e_st1;
    logic        m_win;
    logic [18:0] m_alu;

    assign m_win = (bus.req0 && bus.req1) ? !m_last : bus.req1;
    assign m_alu = alu_ref(m_op, m_a, m_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age <= 0; m_last <= 1'b1; m_owner <= 1'b0;
            e_gnt0 <= 1'b0; e_gnt1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
            e_result <= 16'h0000; e_st0 <= 3'b000; e_st1 <= 3'b000;
        end else begin
            e_gnt0 <= 1'b0; e_gnt1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
            if (m_age == 0) begin
                if (bus.req0 || bus.req1) begin
                    m_owner <= m_win;
                    m_last  <= m_win;
                    m_op    <= m_win ? bus.op1 : bus.op0;
                    m_a     <= m_win ? bus.a1  : bus.a0;
                    m_b     <= m_win ? bus.b1  : bus.b0;
                    e_gnt0  <= !m_win;
                    e_gnt1  <= m_win;
                    m_age   <= 1;
                end
            end else if (m_age == 1) begin
                e_result <= m_alu[18:3];
                e_done0  <= !m_owner;
                e_done1  <= m_owner;
                if (m_op == 2'd1) begin
                    if (m_owner) e_st1 <= m_alu[2:0];
                    else         e_st0 <= m_alu[2:0];
                end
                m_age <= 2;
            end else begin
                m_age <= 0;
            end
        end
    end

    // Continuous comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt0",    bus.gnt0,    e_gnt0);
            chk("gnt1",    bus.gnt1,    e_gnt1);
            chk("done0",   bus.done0,   e_done0);
            chk("done1",   bus.done1,   e_done1);
            chk("result",  bus.result,  e_result);
            chk("status0", bus.status0, e_st0);
            chk("status1", bus.status1, e_st1);
            chk("busy",    bus.busy,    (m_age != 0));
        end
    end

    // One directed transaction from an idle arbiter; req dropped in EXEC
    task automatic txn(input bit who, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] res);
        @(posedge clk); #1;
        if (who) begin bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
        else     begin bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("txn_gnt",  {bus.gnt1, bus.gnt0}, who ? 2'b10 : 2'b01);
        chk("txn_busy", bus.busy, 1'b1);
        @(posedge clk); #1;
        chk("txn_done", {bus.done1, bus.done0}, who ? 2'b10 : 2'b01);
        res = bus.result;
        @(posedge clk); #1;
        chk("txn_idle", bus.busy, 1'b0);
    endtask

    initial begin
        logic [15:0] r;
        rst_n = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 2'd0; bus.op1 = 2'd0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt",    {bus.gnt1, bus.gnt0}, 2'b00);
        chk("rst_done",   {bus.done1, bus.done0}, 2'b00);
        chk("rst_busy",   bus.busy, 1'b0);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_status", {bus.status1, bus.status0}, 6'b000000);
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // single add
        txn(1'b0, 2'd0, 16'h0005, 16'h0003, r);
        chk("add_res", r, 16'h0008);
        chk("add_st0", bus.status0, 3'b000);
        // compare with signed overflow
        txn(1'b1, 2'd1, 16'h8000, 16'h0001, r);
        chk("cmpov_res", r, 16'h7FFF);
        chk("cmpov_st1", bus.status1, 3'b010);
        chk("cmpov_st0", bus.status0, 3'b000);
        // compare equal, then not-B leaves status alone
        txn(1'b0, 2'd1, 16'h1234, 16'h1234, r);
        chk("cmpeq_res", r, 16'h0000);
        chk("cmpeq_st0", bus.status0, 3'b001);
        txn(1'b0, 2'd3, 16'h0000, 16'hFFFF, r);
        chk("notb_res", r, 16'h0000);
        chk("notb_st0", bus.status0, 3'b001);
        chk("notb_st1", bus.status1, 3'b010);

        // reset during EXEC of a requester-1 add
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.op1 = 2'd0; bus.a1 = 16'h0001; bus.b1 = 16'h0002;
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        chk("rmid_gnt1", bus.gnt1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rmid_gnt1_clr", bus.gnt1, 1'b0);
        chk("rmid_busy",     bus.busy, 1'b0);
        chk("rmid_result",   bus.result, 16'h0000);
        chk("rmid_status",   {bus.status1, bus.status0}, 6'b000000);
        @(posedge clk); #1;
        chk("rmid_nodone", {bus.done1, bus.done0}, 2'b00);
        rst_n = 1'b1;

        // contention: both held for four transactions -> 0,1,0,1
        bus.req0 = 1'b1; bus.op0 = 2'd0; bus.a0 = 16'h0100; bus.b0 = 16'h0001;
        bus.req1 = 1'b1; bus.op1 = 2'd2; bus.a1 = 16'hF0F0; bus.b1 = 16'hFF00;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            chk("cont_gnt", {bus.gnt1, bus.gnt0}, (t % 2) ? 2'b10 : 2'b01);
            chk("cont_busy_exec", bus.busy, 1'b1);
            if (t == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            @(posedge clk); #1;
            chk("cont_done", {bus.done1, bus.done0}, (t % 2) ? 2'b10 : 2'b01);
            chk("cont_res", bus.result, (t % 2) ? 16'hF000 : 16'h0101);
            chk("cont_busy_resp", bus.busy, 1'b1);
            @(posedge clk); #1;
            chk("cont_busy_idle", bus.busy, 1'b0);
        end

        // late drop: req0 still high in the IDLE cycle -> second transaction
        bus.req0 = 1'b1; bus.op0 = 2'd0; bus.a0 = 16'h0007; bus.b0 = 16'h0008;
        @(posedge clk); #1;
        chk("late_gnt_a", bus.gnt0, 1'b1);
        @(posedge clk); #1;
        chk("late_done_a", bus.done0, 1'b1);
        chk("late_res_a", bus.result, 16'h000F);
        @(posedge clk); #1;
        chk("late_idle", bus.busy, 1'b0);
        @(posedge clk); #1;
        chk("late_gnt_b", bus.gnt0, 1'b1);
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        chk("late_done_b", bus.done0, 1'b1);
        @(posedge clk); #1;

        // randomized requesters
        repeat (3000) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                bus.req0 = 1'b0; bus.req1 = 1'b0;
                drop_next0 = 1'b0; drop_next1 = 1'b0;
                #1;
                chk("rnd_rst_busy", bus.busy, 1'b0);
                #1 rst_n = 1'b1;
            end else begin
                if (drop_next0) begin
                    bus.req0 = 1'b0; drop_next0 = 1'b0;
                end else if (bus.req0 && bus.gnt0) begin
                    if ($urandom_range(0, 2) == 0) drop_next0 = 1'b1;
                    else                           bus.req0 = 1'b0;
                end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                    bus.req0 = 1'b1; bus.op0 = 2'($urandom);
                    bus.a0 = rnd16(); bus.b0 = rnd16();
                end
                if (drop_next1) begin
                    bus.req1 = 1'b0; drop_next1 = 1'b0;
                end else if (bus.req1 && bus.gnt1) begin
                    if ($urandom_range(0, 2) == 0) drop_next1 = 1'b1;
                    else                           bus.req1 = 1'b0;
                end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                    bus.req1 = 1'b1; bus.op1 = 2'($urandom);
                    bus.a1 = rnd16(); bus.b1 = rnd16();
                end
            end
        end

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port round-robin arbiter that shares one instance of the team's 16-bit ALU between two requesters, for example the instruction datapath and a secondary address/compare unit. It captures operands from the winning requester and runs one ALU operation per transaction. It returns a registered result with a one-cycle done pulse. Each requester also gets its own N/V/Z status register, which updates only on compare (ALUop 01) operations.

## Interface
- W, 16, operand/result width; must match the instantiated ALU width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request from requester 0/1; held high until the matching gnt is seen.
- op0, op1  in  2  ALUop from requester 0/1: 00 add, 01 sub/CMP, 10 and, 11 not-B.
- a0, b0, a1, b1  in  W  operands; must be stable while req is high.
- gnt0, gnt1  out  1  registered one-cycle grant pulse.
- done0, done1  out  1  registered one-cycle completion pulse.
- result  out  W  registered ALU result; valid in the done cycle and held until the next done.
- status0, status1  out  3  per-requester {N,V,Z}; updated only by that requester's op==01.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - req0/req1 are sampled only in this state.
  - If any req is high, select a winner at the clock edge. Capture its op, a and b into the operand registers. Set the matching gnt for the next cycle. Record the winner in the owner and last_grant registers. Go to EXEC.
  - If no req is high, stay in IDLE.
- Arbitration:
  - With a single request, that requester wins.
  - With both requesting, the requester that is not last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first contested cycle.
- EXEC:
  - The ALU evaluates the captured operands combinationally.
  - At the clock edge, register out into result.
  - Assert done[owner] for the next cycle.
  - If the captured op is 01, load status[owner] with {N,V,Z} from the ALU.
  - Go to RESP.
- RESP: done[owner] is high for this cycle only; next state is IDLE unconditionally.
- Requester rule: drop req no later than the RESP cycle. A req still high in the following IDLE cycle is treated as a new request.
- Arithmetic:
  - Results are modulo 2^W.
  - V is the signed-overflow flag from the ALU; it is meaningful only for 00/01.
  - Z means result == 0; N is result[W-1].
  - Ops other than 01 leave both status registers unchanged.
- The non-owning requester's status register is never modified.

## Timing
- Latency: a req high in IDLE edge k gives gnt in cycle k+1 (EXEC) and done plus result in cycle k+2 (RESP).
- Throughput: one transaction per 3 cycles. Back-to-back contention alternates the two requesters.
- Outputs on reset assertion (immediate, asynchronous):
  - state = IDLE.
  - gnt0/gnt1/done0/done1/busy = 0.
  - result = 0.
  - status0 = status1 = 3'b000.
  - last_grant = 1.
- Reset mid-operation (EXEC or RESP): the transaction is aborted with no done pulse and no status update.
- After reset deassertion, the first IDLE edge samples requests normally.
- gnt and done are never both high for the same requester in the same cycle. At most one gnt and one done are high in any cycle.
- A req that rises during EXEC or RESP is ignored until IDLE, with no loss, because the requester holds it.

## Test plan
- Single add: req0, op0=00, a0=0x0005, b0=0x0003 -> gnt0 at +1, done0 at +2, result=0x0008; status0 stays 000.
- CMP overflow: req1, op1=01, a1=0x8000, b1=0x0001 -> result=0x7FFF, status1={N0,V1,Z0}; status0 unchanged.
- CMP equal: req0, op0=01, a0=b0=0x1234 -> result=0x0000, status0={0,0,1}. A following op0=11 with b0=0xFFFF gives result=0x0000 and leaves status0 at {0,0,1}.
- Contention: req0 and req1 both held high continuously for 4 transactions -> grant order 0,1,0,1; each done goes to the matching owner; busy drops only in IDLE cycles.
- Reset mid-op: assert reset during EXEC of a req1 add -> no done1; all outputs 0 immediately; after release, contested req0+req1 grants requester 0 first.
- Late req drop: hold req0 high through RESP -> a second transaction is issued to requester 0 starting in the next IDLE cycle.
